// File: rtl/maze_escaper.sv
// Maze solver using parallel dead-end filling: every clock fills all current
// dead ends at once. Whatever survives when nothing more fills is the path.
module maze_escaper #(
    parameter int size = 11,
    parameter int N    = $clog2(size)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [size-1:0][size-1:0] maze,
    output logic                      done,
    output logic [size-1:0][size-1:0] path,
    output logic                      filling
);
    localparam int            CW   = 2 * N + 1;
    localparam logic [CW-1:0] LAST = CW'(size * size - 1);

    typedef enum logic {FILL, DONE} state_t;

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic [size-1:0][size-1:0] blk;
    logic [size-1:0][size-1:0] dead;
    logic [size+1:0][size+1:0] pad;

    // Blocked border around blk, so out-of-range neighbours read as blocked.
    assign pad[0]      = '1;
    assign pad[size+1] = '1;

    for (genvar r = 0; r < size; r++) begin : g_row
        assign pad[r+1] = {1'b1, blk[r], 1'b1};

        for (genvar c = 0; c < size; c++) begin : g_col
            localparam bit RING = (r == 0) || (r == size - 1) || (c == 0) || (c == size - 1);
            logic up, dn, lf, rt, term, two_open;

            assign up       = ~pad[r][c+1];
            assign dn       = ~pad[r+2][c+1];
            assign lf       = ~pad[r+1][c];
            assign rt       = ~pad[r+1][c+2];
            assign term     = RING && !maze[r][c];
            assign two_open = (up & dn) | (up & lf) | (up & rt) | (dn & lf) | (dn & rt) | (lf & rt);
            assign dead[r][c] = !blk[r][c] && !term && !two_open;
        end
    end

    assign filling = (state == FILL);

    always_ff @(posedge clk) begin
        if (!rst) begin
            blk   <= maze;
            path  <= '0;
            done  <= 1'b0;
            cnt   <= '0;
            state <= FILL;
        end else begin
            case (state)
                FILL: begin
                    blk <= blk | dead;
                    cnt <= cnt + 1'b1;
                    // Path is taken from blk before this edge's fill.
                    if (dead == '0 || cnt == LAST) begin
                        path  <= ~blk;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= DONE;
            endcase
        end
    end
endmodule

// File: tb/tb_maze_escaper.sv
// Bench for maze_escaper: a 5x5 and a 7x7 instance, directed mazes, with a
// scoreboard queue per instance checked by a monitor when done rises.
module tb_maze_escaper;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst5 = 1'b0, rst7 = 1'b0;
    logic [4:0][4:0]  maze5 = '1, path5;
    logic [6:0][6:0]  maze7 = '1, path7;
    logic             done5, done7, fill5, fill7;

    maze_escaper #(.size(5)) dut5 (
        .clk(clk), .rst(rst5), .maze(maze5), .done(done5), .path(path5), .filling(fill5)
    );
    maze_escaper #(.size(7)) dut7 (
        .clk(clk), .rst(rst7), .maze(maze7), .done(done7), .path(path7), .filling(fill7)
    );

    int errors = 0;
    int checks = 0;

    // Entries are {latency[7:0], path}.
    logic [32:0] exp5_q[$];
    logic [56:0] exp7_q[$];
    logic [32:0] e5;
    logic [56:0] e7;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FILL edges since reset release, counted up to and including the done edge.
    int lat5 = 0, lat7 = 0;
    always @(posedge clk) begin
        if (!rst5) lat5 <= 0; else if (!done5) lat5 <= lat5 + 1;
        if (!rst7) lat7 <= 0; else if (!done7) lat7 <= lat7 + 1;
    end

    // Monitors: pop and compare on each rising done.
    initial begin
        bit seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!done5) seen = 1'b0;
            else if (!seen) begin
                seen = 1'b1;
                if (exp5_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb5_unexpected: done rose with empty queue");
                end else begin
                    e5 = exp5_q.pop_front();
                    check("sb5_path", 64'(path5), 64'(e5[24:0]));
                    check("sb5_latency", 64'(lat5), 64'(e5[32:25]));
                    check("sb5_no_wall", 64'(path5 & maze5), 64'd0);
                end
            end
        end
    end

    initial begin
        bit seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!done7) seen = 1'b0;
            else if (!seen) begin
                seen = 1'b1;
                if (exp7_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb7_unexpected: done rose with empty queue");
                end else begin
                    e7 = exp7_q.pop_front();
                    check("sb7_path", 64'(path7), 64'(e7[48:0]));
                    check("sb7_latency", 64'(lat7), 64'(e7[56:49]));
                    check("sb7_no_wall", 64'(path7 & maze7), 64'd0);
                end
            end
        end
    end

    task automatic run5(input string name, input logic [4:0][4:0] m,
                        input logic [4:0][4:0] p, input int lat);
        int n = 0;
        int bad = 0;
        @(negedge clk);
        maze5 = m;
        rst5  = 1'b0;
        @(negedge clk);
        check({name, "_rst_done"}, 64'(done5), 64'd0);
        check({name, "_rst_path"}, 64'(path5), 64'd0);
        check({name, "_rst_fill"}, 64'(fill5), 64'd1);
        exp5_q.push_back({lat[7:0], p});
        rst5 = 1'b1;
        while (!done5 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done5) begin
            checks++; errors++;
            $display("FAIL %s_timeout: done=%0b after %0d cycles, required 1", name, done5, n);
        end
        // Maze changes after done must not disturb the result.
        maze5 = '0;
        repeat (100) begin
            @(negedge clk);
            if (path5 !== p || done5 !== 1'b1 || fill5 !== 1'b0) bad++;
        end
        check({name, "_hold"}, 64'(bad), 64'd0);
    endtask

    task automatic run7(input string name, input logic [6:0][6:0] m,
                        input logic [6:0][6:0] p, input int lat, input bit mid_reset);
        int n = 0;
        int bad = 0;
        @(negedge clk);
        maze7 = m;
        rst7  = 1'b0;
        @(negedge clk);
        check({name, "_rst_done"}, 64'(done7), 64'd0);
        check({name, "_rst_path"}, 64'(path7), 64'd0);
        exp7_q.push_back({lat[7:0], p});
        rst7 = 1'b1;
        if (mid_reset) begin
            repeat (2) @(negedge clk);
            check({name, "_mid_fill"}, 64'(fill7), 64'd1);
            rst7 = 1'b0;
            @(negedge clk);
            check({name, "_mid_done"}, 64'(done7), 64'd0);
            check({name, "_mid_path"}, 64'(path7), 64'd0);
            rst7 = 1'b1;
        end
        while (!done7 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done7) begin
            checks++; errors++;
            $display("FAIL %s_timeout: done=%0b after %0d cycles, required 1", name, done7, n);
        end
        maze7 = '0;
        repeat (100) begin
            @(negedge clk);
            if (path7 !== p || done7 !== 1'b1 || fill7 !== 1'b0) bad++;
        end
        check({name, "_hold"}, 64'(bad), 64'd0);
    endtask

    // Row literals: bit c is column c; concatenations list the last row first.
    logic [6:0][6:0] serp_maze, serp_path;

    initial begin
        serp_maze = {7'b1011111, 7'b1000011, 7'b1011111, 7'b1010001,
                     7'b1010101, 7'b1000101, 7'b1111101};
        serp_path = {7'b0100000, 7'b0100000, 7'b0100000, 7'b0101110,
                     7'b0101010, 7'b0111010, 7'b0000010};

        repeat (2) @(negedge clk);

        run5("corridor", {5{5'b11011}}, {5{5'b00100}}, 1);
        run5("stubs",
             {5'b11011, 5'b11011, 5'b11011, 5'b10001, 5'b11011},
             {5{5'b00100}}, 2);
        run5("loop",
             {5'b11011, 5'b10001, 5'b10001, 5'b10001, 5'b11011},
             {5'b00100, 5'b01110, 5'b01110, 5'b01110, 5'b00100}, 1);
        run5("one_open",
             {5'b11111, 5'b11011, 5'b11011, 5'b10001, 5'b11011},
             {20'b0, 5'b00100}, 4);

        run7("serp", serp_maze, serp_path, 4, 1'b0);
        run7("serp_rst", serp_maze, serp_path, 4, 1'b1);

        check("q5_empty", 64'(exp5_q.size()), 64'd0);
        check("q7_empty", 64'(exp7_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
